// File: rtl/friscv_fence_i_sequencer_pkg.sv
// rtl/friscv_fence_i_sequencer_pkg.sv - shared types for the FENCE.i sequencer
package friscv_fence_i_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    REQ      = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4
  } fence_fsm;

  function automatic int cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/friscv_fence_outstanding_cnt.sv
// rtl/friscv_fence_outstanding_cnt.sv - saturating up/down count of in-flight fetch reads
module friscv_fence_outstanding_cnt
  import friscv_fence_i_sequencer_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
  input  logic             aclk,
  input  logic             srst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic do_inc;
  logic do_dec;

  // A completion with nothing in flight is dropped rather than wrapping.
  always_comb begin
    do_inc = inc && (count != MAX_CNT);
    do_dec = dec && (count != '0);
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      count <= '0;
    end else if (do_inc && !do_dec) begin
      count <= count + CNT_W'(1);
    end else if (do_dec && !do_inc) begin
      count <= count - CNT_W'(1);
    end
  end

  assign full = (count == MAX_CNT);

endmodule

// File: rtl/friscv_fence_i_sequencer.sv
// rtl/friscv_fence_i_sequencer.sv - FENCE.i initiator: stall fetch, drain reads, flush I$, report
module friscv_fence_i_sequencer
  import friscv_fence_i_sequencer_pkg::*;
#(
  parameter string NAME            = "FenceI-Sequencer",
  parameter int    MAX_OUTSTANDING = 8,
  parameter int    TIMEOUT_W       = 16,
  parameter int    CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             aclk,
  input  logic             srst,
  input  logic             fence_i_valid,
  output logic             fence_i_ready,
  output logic             fence_error,
  input  logic             fetch_req_valid,
  input  logic             fetch_req_ready,
  input  logic             fetch_cpl_valid,
  output logic             fetch_stall,
  output logic [CNT_W-1:0] outstanding,
  input  logic             cache_ready,
  input  logic             flushing,
  output logic             flush_blocks,
  input  logic             flush_ack
);

  if (MAX_OUTSTANDING < 1) begin : g_param_check
    $fatal(1, "%s: MAX_OUTSTANDING must be >= 1", NAME);
  end

  // tmo_cnt holds the number of WAIT_ACK cycles already spent; the cycle whose
  // increment would reach all-ones is the last one, giving 2^W-1 cycles total.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  fence_fsm             state;
  fence_fsm             state_nxt;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 tmo_expired;
  logic                 drain_done;
  logic                 cnt_full;

  friscv_fence_outstanding_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_outstanding_cnt (
    .aclk  (aclk),
    .srst  (srst),
    .inc   (fetch_req_valid & fetch_req_ready),
    .dec   (fetch_cpl_valid),
    .count (outstanding),
    .full  (cnt_full)
  );

  always_comb begin
    tmo_expired = (tmo_cnt == TMO_LAST);
    drain_done  = (outstanding == '0) && !fetch_cpl_valid && cache_ready && !flushing;
    state_nxt   = state;
    case (state)
      IDLE:     if (fence_i_valid) state_nxt = DRAIN;
      DRAIN:    if (drain_done) state_nxt = REQ;
      REQ:      state_nxt = WAIT_ACK;
      WAIT_ACK: if (flush_ack || tmo_expired) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      fence_error   <= 1'b0;
      flush_blocks  <= 1'b0;
      fence_i_ready <= 1'b0;
    end else begin
      state         <= state_nxt;
      tmo_cnt       <= (state == WAIT_ACK) ? tmo_cnt + TIMEOUT_W'(1) : '0;
      flush_blocks  <= (state_nxt == REQ);
      fence_i_ready <= (state_nxt == DONE);
      // An ack arriving on the expiry cycle wins over the timeout.
      if (state == IDLE && state_nxt == DRAIN) begin
        fence_error <= 1'b0;
      end else if (state == WAIT_ACK && tmo_expired && !flush_ack) begin
        fence_error <= 1'b1;
      end
    end
  end

  assign fetch_stall = (state != IDLE) | cnt_full | !cache_ready;

endmodule

// File: tb/tb_friscv_fence_i_sequencer.sv
// tb/tb_friscv_fence_i_sequencer.sv - scoreboard bench for the FENCE.i sequencer
module tb_friscv_fence_i_sequencer;

  localparam int MAX_OUT    = 8;
  localparam int TW         = 4;
  localparam int CW         = $clog2(MAX_OUT + 1);
  localparam int TMO_CYCLES = (1 << TW) - 1;

  logic          aclk = 1'b0;
  logic          srst;
  logic          fence_i_valid;
  logic          fence_i_ready;
  logic          fence_error;
  logic          fetch_req_valid;
  logic          fetch_req_ready;
  logic          fetch_cpl_valid;
  logic          fetch_stall;
  logic [CW-1:0] outstanding;
  logic          cache_ready;
  logic          flushing;
  logic          flush_blocks;
  logic          flush_ack;

  friscv_fence_i_sequencer #(
    .MAX_OUTSTANDING (MAX_OUT),
    .TIMEOUT_W       (TW)
  ) dut (
    .aclk            (aclk),
    .srst            (srst),
    .fence_i_valid   (fence_i_valid),
    .fence_i_ready   (fence_i_ready),
    .fence_error     (fence_error),
    .fetch_req_valid (fetch_req_valid),
    .fetch_req_ready (fetch_req_ready),
    .fetch_cpl_valid (fetch_cpl_valid),
    .fetch_stall     (fetch_stall),
    .outstanding     (outstanding),
    .cache_ready     (cache_ready),
    .flushing        (flushing),
    .flush_blocks    (flush_blocks),
    .flush_ack       (flush_ack)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int cyc;
    bit err;
  } done_t;

  int    cyc        = 0;
  int    model_cnt  = 0;
  int    checks     = 0;
  int    passed     = 0;
  bit    fence_busy = 1'b0;
  bit    mon_en     = 1'b0;
  int    flush_q[$];
  done_t done_q[$];
  done_t mon_d;

  always @(posedge aclk) cyc <= cyc + 1;

  // Reference in-flight count: accepted reads minus completions, never below zero.
  always @(posedge aclk) begin
    if (srst) model_cnt <= 0;
    else model_cnt <= model_cnt + ((fetch_req_valid && fetch_req_ready) ? 1 : 0)
                                - ((fetch_cpl_valid && model_cnt > 0) ? 1 : 0);
  end

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void unexpected(input string name);
    checks++;
    $display("FAIL %s: got 1 expected 0 (cycle %0d)", name, cyc);
  endfunction

  always @(negedge aclk) begin
    #1;
    if (mon_en) begin
      check("outstanding", outstanding, model_cnt);
      check("fetch_stall", fetch_stall, (fence_busy || model_cnt == MAX_OUT || !cache_ready));
      if (flush_blocks) begin
        if (flush_q.size() == 0) unexpected("flush_blocks_unexpected");
        else check("flush_blocks_cycle", cyc, flush_q.pop_front());
      end
      if (fence_i_ready) begin
        if (done_q.size() == 0) unexpected("fence_i_ready_unexpected");
        else begin
          mon_d = done_q.pop_front();
          check("fence_i_ready_cycle", cyc, mon_d.cyc);
          check("fence_error", fence_error, mon_d.err);
        end
      end
    end
  end

  task automatic tick();
    @(negedge aclk);
    srst            = 1'b0;
    fetch_req_valid = 1'b0;
    fetch_req_ready = 1'b1;
    fetch_cpl_valid = 1'b0;
    flush_ack       = 1'b0;
  endtask

  task automatic set_req();
    fetch_req_valid = 1'b1;
    fetch_req_ready = 1'b1;
  endtask

  task automatic idle_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      fetch_req_ready = 1'($urandom_range(0, 1));
      if (model_cnt < MAX_OUT && cache_ready && $urandom_range(0, 1) == 1) fetch_req_valid = 1'b1;
      if ($urandom_range(0, 2) == 0 && !(model_cnt == 0 && fetch_req_valid && fetch_req_ready))
        fetch_cpl_valid = 1'b1;
    end
  endtask

  // ack_at: index of the WAIT_ACK cycle carrying flush_ack (<0: never).
  // With do_reset, srst is driven on that WAIT_ACK cycle instead.
  task automatic run_fence(input int busy, input int ack_at, input bit pre_read, input bit do_reset);
    int    f_cyc;
    int    w0;
    int    guard;
    done_t e;
    tick();
    fence_i_valid = 1'b1;
    if (pre_read && model_cnt < MAX_OUT) set_req();
    f_cyc = -1;
    guard = 0;
    while (f_cyc < 0 && guard < 300) begin
      tick();
      guard++;
      fence_busy = 1'b1;
      if (busy > 0) begin
        busy--;
        cache_ready = 1'($urandom_range(0, 1));
        flushing    = cache_ready ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
        cache_ready = 1'b1;
        flushing    = 1'b0;
      end
      if (model_cnt > 0 && $urandom_range(0, 2) == 0) fetch_cpl_valid = 1'b1;
      if (model_cnt == 0 && !fetch_cpl_valid && cache_ready && !flushing) f_cyc = cyc + 1;
    end
    if (f_cyc < 0) begin
      unexpected("drain_never_completed");
      srst          = 1'b1;
      fence_i_valid = 1'b0;
      tick();
      fence_busy = 1'b0;
      return;
    end
    flush_q.push_back(f_cyc);
    tick();
    w0 = f_cyc + 1;
    if (do_reset) begin
      for (int k = 0; k <= ack_at; k++) tick();
      srst          = 1'b1;
      fence_i_valid = 1'b0;
      tick();
      fence_busy = 1'b0;
      check("rst_fence_i_ready", fence_i_ready, 0);
      check("rst_fence_error", fence_error, 0);
      check("rst_flush_blocks", flush_blocks, 0);
      check("rst_outstanding", outstanding, 0);
      check("rst_fetch_stall", fetch_stall, !cache_ready);
      return;
    end
    if (ack_at >= 0 && ack_at < TMO_CYCLES) begin
      e.cyc = w0 + ack_at + 1;
      e.err = 1'b0;
    end else begin
      e.cyc = w0 + TMO_CYCLES;
      e.err = 1'b1;
    end
    done_q.push_back(e);
    while (cyc < e.cyc) begin
      tick();
      if (ack_at >= 0 && cyc == w0 + ack_at) flush_ack = 1'b1;
    end
    fence_i_valid = 1'b0;
    tick();
    fence_busy = 1'b0;
    flush_ack  = 1'($urandom_range(0, 1));
  endtask

  task automatic counter_directed();
    while (model_cnt > 0) begin
      tick();
      if (model_cnt > 0) fetch_cpl_valid = 1'b1;
    end
    tick(); set_req();
    tick(); set_req();
    tick(); set_req(); fetch_cpl_valid = 1'b1;
    tick();
    check("simul_req_cpl_at_2", outstanding, 2);
    set_req();
    for (int i = 0; i < 5; i++) begin
      tick();
      set_req();
    end
    tick();
    check("fill_count", outstanding, MAX_OUT);
    check("fill_stall", fetch_stall, 1);
    fetch_cpl_valid = 1'b1;
    for (int i = 0; i < MAX_OUT - 1; i++) begin
      tick();
      fetch_cpl_valid = 1'b1;
    end
    tick();
    check("emptied_count", outstanding, 0);
    fetch_cpl_valid = 1'b1;
    tick();
    check("cpl_at_zero", outstanding, 0);
  endtask

  initial begin
    srst            = 1'b1;
    fence_i_valid   = 1'b0;
    fetch_req_valid = 1'b0;
    fetch_req_ready = 1'b1;
    fetch_cpl_valid = 1'b0;
    cache_ready     = 1'b0;
    flushing        = 1'b1;
    flush_ack       = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check("reset_fence_i_ready", fence_i_ready, 0);
    check("reset_fence_error", fence_error, 0);
    check("reset_flush_blocks", flush_blocks, 0);
    check("reset_outstanding", outstanding, 0);
    check("reset_fetch_stall", fetch_stall, 1);
    mon_en = 1'b1;
    tick();
    tick();
    cache_ready = 1'b1;
    flushing    = 1'b0;
    tick();
    check("ready_fetch_stall", fetch_stall, 0);

    run_fence(0, 4, 0, 0);
    counter_directed();
    tick(); set_req();
    tick(); set_req();
    tick(); set_req();
    run_fence(0, 3, 0, 0);
    run_fence(0, -1, 0, 0);
    run_fence(0, 2, 1, 0);
    run_fence(0, TMO_CYCLES - 1, 0, 0);
    run_fence(0, TMO_CYCLES, 0, 0);
    run_fence(6, 3, 0, 0);
    tick(); flush_ack = 1'b1;
    tick(); tick();
    idle_traffic(5);
    run_fence(0, 5, 1, 1);
    run_fence(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      idle_traffic($urandom_range(0, 10));
      run_fence($urandom_range(0, 4), $urandom_range(0, 17) - 1, 1'($urandom_range(0, 1)), 1'b0);
    end
    repeat (4) tick();
    check("flush_q_drained", flush_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
